// File: rtl/fft_mem_pkg.sv
// rtl/fft_mem_pkg.sv - shared constants and helpers for the FFT ping-pong buffer
package fft_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_ADDR_W = 16;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  // Reverses the low w bits of a; bits at and above w come back as zero.
  function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] a, input int w);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      r[i] = a[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pingpong_mem_ctl_if.sv
// rtl/fft_pingpong_mem_ctl_if.sv - fill stream, butterfly access and status bundle
interface fft_pingpong_mem_ctl_if
  import fft_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W:0]   fill_count;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;

  logic              wr_en_a;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [DATA_W-1:0] wr_data_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_addr_b;
  logic [DATA_W-1:0] wr_data_b;

  logic              proc_done;
  logic              proc_busy;
  logic              bank_sel;
  logic              swap;

  modport master (
    output in_valid, in_data,
    output rd_en, rd_addr_a, rd_addr_b,
    output wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b,
    output proc_done,
    input  in_ready, fill_count, rd_data_a, rd_data_b, rd_valid,
    input  proc_busy, bank_sel, swap
  );

  modport slave (
    input  in_valid, in_data,
    input  rd_en, rd_addr_a, rd_addr_b,
    input  wr_en_a, wr_addr_a, wr_data_a, wr_en_b, wr_addr_b, wr_data_b,
    input  proc_done,
    output in_ready, fill_count, rd_data_a, rd_data_b, rd_valid,
    output proc_busy, bank_sel, swap
  );

endinterface

// File: rtl/fft_mem_bank.sv
// rtl/fft_mem_bank.sv - DEPTH x DATA_W register bank, two write ports (B wins), two registered reads
module fft_mem_bank
  import fft_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_b,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Port B is written last so it overrides port A on an address clash.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en_a) mem[wr_addr_a] <= wr_data_a;
      if (wr_en_b) mem[wr_addr_b] <= wr_data_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
    end
  end

endmodule

// File: rtl/fft_pingpong_mem_ctl.sv
// rtl/fft_pingpong_mem_ctl.sv - ping-pong buffer: fill counter, bank swap control and port muxing
module fft_pingpong_mem_ctl
  import fft_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BITREV_IN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_pingpong_mem_ctl_if.slave bus
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);

  logic              bank_sel, bank_sel_n;
  logic              proc_busy, proc_busy_n;
  logic              swap, swap_n;
  logic [ADDR_W:0]   fill_count, fill_count_n;
  logic              rd_valid;
  logic              rd_bank;

  logic              in_ready;
  logic              fill_fire;
  logic              swap_go;
  logic [ADDR_W-1:0] fill_addr;

  logic              bk_wr_en_a    [2];
  logic              bk_wr_en_b    [2];
  logic              bk_rd_en      [2];
  logic [ADDR_W-1:0] bk_wr_addr_a  [2];
  logic [ADDR_W-1:0] bk_wr_addr_b  [2];
  logic [DATA_W-1:0] bk_wr_data_a  [2];
  logic [DATA_W-1:0] bk_wr_data_b  [2];
  logic [DATA_W-1:0] bk_rd_data_a  [2];
  logic [DATA_W-1:0] bk_rd_data_b  [2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_sel   <= BANK0;
      proc_busy  <= 1'b0;
      swap       <= 1'b0;
      fill_count <= '0;
      rd_valid   <= 1'b0;
      rd_bank    <= BANK0;
    end else begin
      bank_sel   <= bank_sel_n;
      proc_busy  <= proc_busy_n;
      swap       <= swap_n;
      fill_count <= fill_count_n;
      rd_valid   <= bus.rd_en;
      // Remember which bank answered so the output holds across a later swap.
      if (bus.rd_en) rd_bank <= bank_sel;
    end
  end

  always_comb begin
    bank_sel_n   = bank_sel;
    proc_busy_n  = proc_busy;
    swap_n       = 1'b0;
    fill_count_n = fill_count;
    if (swap_go) begin
      bank_sel_n   = ~bank_sel;
      proc_busy_n  = 1'b1;
      swap_n       = 1'b1;
      fill_count_n = '0;
    end else begin
      if (fill_fire) fill_count_n = fill_count + 1'b1;
      if (bus.proc_done && proc_busy) proc_busy_n = 1'b0;
    end
  end

  always_comb begin
    in_ready  = (fill_count != FULL);
    fill_fire = bus.in_valid && in_ready;
    swap_go   = (fill_count == FULL) && !proc_busy;
    if (BITREV_IN != 0) begin
      fill_addr = ADDR_W'(bitrev(MAX_ADDR_W'(fill_count[ADDR_W-1:0]), ADDR_W));
    end else begin
      fill_addr = fill_count[ADDR_W-1:0];
    end
  end

  // The processing bank takes butterfly traffic; the other bank only sees fill writes on port A.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bk_wr_en_a[b]   = 1'b0;
      bk_wr_en_b[b]   = 1'b0;
      bk_rd_en[b]     = 1'b0;
      bk_wr_addr_a[b] = fill_addr;
      bk_wr_addr_b[b] = bus.wr_addr_b;
      bk_wr_data_a[b] = bus.in_data;
      bk_wr_data_b[b] = bus.wr_data_b;
      if (bank_sel == 1'(b)) begin
        bk_wr_en_a[b]   = proc_busy && bus.wr_en_a;
        bk_wr_en_b[b]   = proc_busy && bus.wr_en_b;
        bk_rd_en[b]     = bus.rd_en;
        bk_wr_addr_a[b] = bus.wr_addr_a;
        bk_wr_data_a[b] = bus.wr_data_a;
      end else begin
        bk_wr_en_a[b]   = fill_fire;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_mem_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_a   (bk_wr_en_a[g]),
      .wr_addr_a (bk_wr_addr_a[g]),
      .wr_data_a (bk_wr_data_a[g]),
      .wr_en_b   (bk_wr_en_b[g]),
      .wr_addr_b (bk_wr_addr_b[g]),
      .wr_data_b (bk_wr_data_b[g]),
      .rd_en     (bk_rd_en[g]),
      .rd_addr_a (bus.rd_addr_a),
      .rd_addr_b (bus.rd_addr_b),
      .rd_data_a (bk_rd_data_a[g]),
      .rd_data_b (bk_rd_data_b[g])
    );
  end

  assign bus.in_ready   = in_ready;
  assign bus.fill_count = fill_count;
  assign bus.proc_busy  = proc_busy;
  assign bus.bank_sel   = bank_sel;
  assign bus.swap       = swap;
  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data_a  = (rd_bank == BANK1) ? bk_rd_data_a[1] : bk_rd_data_a[0];
  assign bus.rd_data_b  = (rd_bank == BANK1) ? bk_rd_data_b[1] : bk_rd_data_b[0];

endmodule

// File: tb/tb_fft_pingpong_mem_ctl.sv
// tb/tb_fft_pingpong_mem_ctl.sv - directed and random checks of the ping-pong buffer against a frame-level model
module tb_fft_pingpong_mem_ctl;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int N  = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_pingpong_mem_ctl_if #(.DATA_W(DW), .ADDR_W(AW)) bus_rev ();
  fft_pingpong_mem_ctl_if #(.DATA_W(DW), .ADDR_W(AW)) bus_nat ();

  fft_pingpong_mem_ctl #(.DATA_W(DW), .ADDR_W(AW), .BITREV_IN(1)) dut_rev (
    .clk (clk),
    .rst (rst),
    .bus (bus_rev.slave)
  );

  fft_pingpong_mem_ctl #(.DATA_W(DW), .ADDR_W(AW), .BITREV_IN(0)) dut_nat (
    .clk (clk),
    .rst (rst),
    .bus (bus_nat.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_mem [2][N];
  int         m_sel;
  int         m_cnt;
  bit         m_busy;
  bit         m_swap;
  bit         m_rd_valid;
  logic [7:0] m_rd_a;
  logic [7:0] m_rd_b;
  logic [7:0] old_a;
  logic [7:0] old_b;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev5(input int v);
    int r = 0;
    for (int i = 0; i < AW; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < N; a++) m_mem[b][a] = 8'h00;
    m_sel = 0; m_cnt = 0; m_busy = 0; m_swap = 0; m_rd_valid = 0;
    m_rd_a = 8'h00; m_rd_b = 8'h00;
  endtask

  // Applies one clock edge of the documented behaviour using the inputs currently driven.
  task automatic model_edge();
    int s = m_sel;
    int c = m_cnt;
    bit b = m_busy;
    if (bus_rev.rd_en) begin
      m_rd_a = m_mem[s][bus_rev.rd_addr_a];
      m_rd_b = m_mem[s][bus_rev.rd_addr_b];
    end
    m_rd_valid = bus_rev.rd_en;
    if (b) begin
      if (bus_rev.wr_en_a) m_mem[s][bus_rev.wr_addr_a] = bus_rev.wr_data_a;
      if (bus_rev.wr_en_b) m_mem[s][bus_rev.wr_addr_b] = bus_rev.wr_data_b;
    end
    if (bus_rev.in_valid && c != N) begin
      m_mem[1-s][rev5(c)] = bus_rev.in_data;
      m_cnt = c + 1;
    end
    m_swap = 0;
    if (c == N && !b) begin
      m_sel = 1 - s; m_cnt = 0; m_busy = 1; m_swap = 1;
    end else if (bus_rev.proc_done && b) begin
      m_busy = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".in_ready"},   16'(bus_rev.in_ready),   16'(m_cnt != N));
    check({tag, ".fill_count"}, 16'(bus_rev.fill_count), 16'(m_cnt));
    check({tag, ".proc_busy"},  16'(bus_rev.proc_busy),  16'(m_busy));
    check({tag, ".bank_sel"},   16'(bus_rev.bank_sel),   16'(m_sel));
    check({tag, ".swap"},       16'(bus_rev.swap),       16'(m_swap));
    check({tag, ".rd_valid"},   16'(bus_rev.rd_valid),   16'(m_rd_valid));
    check({tag, ".rd_data_a"},  16'(bus_rev.rd_data_a),  16'(m_rd_a));
    check({tag, ".rd_data_b"},  16'(bus_rev.rd_data_b),  16'(m_rd_b));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_rev();
    bus_rev.in_valid = 0; bus_rev.in_data = 8'h00;
    bus_rev.rd_en = 0; bus_rev.rd_addr_a = 5'd0; bus_rev.rd_addr_b = 5'd0;
    bus_rev.wr_en_a = 0; bus_rev.wr_addr_a = 5'd0; bus_rev.wr_data_a = 8'h00;
    bus_rev.wr_en_b = 0; bus_rev.wr_addr_b = 5'd0; bus_rev.wr_data_b = 8'h00;
    bus_rev.proc_done = 0;
  endtask

  task automatic idle_nat();
    bus_nat.in_valid = 0; bus_nat.in_data = 8'h00;
    bus_nat.rd_en = 0; bus_nat.rd_addr_a = 5'd0; bus_nat.rd_addr_b = 5'd0;
    bus_nat.wr_en_a = 0; bus_nat.wr_addr_a = 5'd0; bus_nat.wr_data_a = 8'h00;
    bus_nat.wr_en_b = 0; bus_nat.wr_addr_b = 5'd0; bus_nat.wr_data_b = 8'h00;
    bus_nat.proc_done = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_rev();
    idle_nat();
    model_reset();
    #1;
    check("reset.fill_count", 16'(bus_rev.fill_count), 16'd0);
    check("reset.bank_sel",   16'(bus_rev.bank_sel),   16'd0);
    check("reset.proc_busy",  16'(bus_rev.proc_busy),  16'd0);
    check("reset.swap",       16'(bus_rev.swap),       16'd0);
    check("reset.rd_valid",   16'(bus_rev.rd_valid),   16'd0);
    check("reset.rd_data_a",  16'(bus_rev.rd_data_a),  16'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("release.in_ready", 16'(bus_rev.in_ready), 16'd1);

    // Frame 1: counting pattern through bit-reversed fill.
    for (int i = 0; i < N; i++) begin
      bus_rev.in_valid = 1; bus_rev.in_data = 8'(i);
      step("fill1");
    end
    check("fill1.in_ready_full", 16'(bus_rev.in_ready),   16'd0);
    check("fill1.count_full",    16'(bus_rev.fill_count), 16'd32);
    bus_rev.in_valid = 0;
    step("swap1");
    check("swap1.swap",     16'(bus_rev.swap),      16'd1);
    check("swap1.bank_sel", 16'(bus_rev.bank_sel),  16'd1);
    check("swap1.busy",     16'(bus_rev.proc_busy), 16'd1);
    bus_rev.rd_en = 1; bus_rev.rd_addr_a = 5'd1; bus_rev.rd_addr_b = 5'd3;
    step("rd1");
    bus_rev.rd_en = 0;
    check("rd1.addr1", 16'(bus_rev.rd_data_a), 16'h10);
    check("rd1.addr3", 16'(bus_rev.rd_data_b), 16'h18);
    check("rd1.valid", 16'(bus_rev.rd_valid),  16'd1);

    // Frame 2 fills while the first is still in work; extra samples must be refused.
    for (int i = 0; i < N + 4; i++) begin
      bus_rev.in_valid = 1; bus_rev.in_data = 8'($urandom);
      bus_rev.rd_en = 1'($urandom); bus_rev.rd_addr_a = 5'($urandom); bus_rev.rd_addr_b = 5'($urandom);
      step("fill2");
    end
    bus_rev.in_valid = 0; bus_rev.rd_en = 0;
    check("fill2.count_hold", 16'(bus_rev.fill_count), 16'd32);
    check("fill2.no_swap",    16'(bus_rev.swap),       16'd0);
    bus_rev.proc_done = 1;
    step("done2");
    bus_rev.proc_done = 0;
    check("done2.busy_clear", 16'(bus_rev.proc_busy), 16'd0);
    check("done2.bank_hold",  16'(bus_rev.bank_sel),  16'd1);
    step("swap2");
    check("swap2.swap",     16'(bus_rev.swap),       16'd1);
    check("swap2.bank_sel", 16'(bus_rev.bank_sel),   16'd0);
    check("swap2.count",    16'(bus_rev.fill_count), 16'd0);

    // Dual write to one address with a same-edge read: old data out, port B lands.
    old_a = m_mem[0][7];
    bus_rev.wr_en_a = 1; bus_rev.wr_addr_a = 5'd7; bus_rev.wr_data_a = 8'hAA;
    bus_rev.wr_en_b = 1; bus_rev.wr_addr_b = 5'd7; bus_rev.wr_data_b = 8'h55;
    bus_rev.rd_en = 1; bus_rev.rd_addr_a = 5'd7; bus_rev.rd_addr_b = 5'd7;
    step("coll");
    check("coll.read_first", 16'(bus_rev.rd_data_a), 16'(old_a));
    bus_rev.wr_en_a = 0; bus_rev.wr_en_b = 0;
    step("coll_rd");
    bus_rev.rd_en = 0;
    check("coll.b_wins", 16'(bus_rev.rd_data_a), 16'h55);

    // Writes and proc_done while idle must change nothing.
    bus_rev.proc_done = 1;
    step("release");
    bus_rev.proc_done = 0;
    old_b = m_mem[0][2];
    bus_rev.wr_en_a = 1; bus_rev.wr_addr_a = 5'd2; bus_rev.wr_data_a = 8'hEE;
    step("idle_wr");
    bus_rev.wr_en_a = 0;
    bus_rev.proc_done = 1;
    step("idle_done");
    bus_rev.proc_done = 0;
    check("idle.busy", 16'(bus_rev.proc_busy), 16'd0);
    check("idle.sel",  16'(bus_rev.bank_sel),  16'd0);
    bus_rev.rd_en = 1; bus_rev.rd_addr_a = 5'd2;
    step("idle_rd");
    bus_rev.rd_en = 0;
    check("idle.mem_unchanged", 16'(bus_rev.rd_data_a), 16'(old_b));

    // Reset part way through a frame.
    for (int i = 0; i < 10; i++) begin
      bus_rev.in_valid = 1; bus_rev.in_data = 8'($urandom);
      step("fill3");
    end
    bus_rev.in_valid = 0;
    rst = 1'b0;
    #1;
    model_reset();
    check("midrst.fill_count", 16'(bus_rev.fill_count), 16'd0);
    check("midrst.bank_sel",   16'(bus_rev.bank_sel),   16'd0);
    check("midrst.proc_busy",  16'(bus_rev.proc_busy),  16'd0);
    check("midrst.rd_valid",   16'(bus_rev.rd_valid),   16'd0);
    check("midrst.rd_data_a",  16'(bus_rev.rd_data_a),  16'd0);
    check("midrst.rd_data_b",  16'(bus_rev.rd_data_b),  16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst.in_ready", 16'(bus_rev.in_ready), 16'd1);
    for (int i = 0; i < N; i++) begin
      bus_rev.rd_en = 1; bus_rev.rd_addr_a = 5'(i); bus_rev.rd_addr_b = 5'(N - 1 - i);
      step("post_rst_rd");
      check("post_rst.zero_a", 16'(bus_rev.rd_data_a), 16'd0);
    end
    bus_rev.rd_en = 0;

    // Random traffic on every port, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      bus_rev.in_valid  = ($urandom % 4) != 0;
      bus_rev.in_data   = 8'($urandom);
      bus_rev.rd_en     = 1'($urandom);
      bus_rev.rd_addr_a = 5'($urandom); bus_rev.rd_addr_b = 5'($urandom);
      bus_rev.wr_en_a   = 1'($urandom);
      bus_rev.wr_addr_a = 5'($urandom); bus_rev.wr_data_a = 8'($urandom);
      bus_rev.wr_en_b   = 1'($urandom);
      bus_rev.wr_addr_b = 5'($urandom); bus_rev.wr_data_b = 8'($urandom);
      bus_rev.proc_done = ($urandom % 12) == 0;
      step("rand");
    end
    idle_rev();

    // Natural-order instance: fill 0x40.. and read back by address.
    for (int i = 0; i < N; i++) begin
      bus_nat.in_valid = 1; bus_nat.in_data = 8'(8'h40 + i);
      step("nat_fill");
    end
    bus_nat.in_valid = 0;
    step("nat_swap");
    check("nat.swap",     16'(bus_nat.swap),     16'd1);
    check("nat.bank_sel", 16'(bus_nat.bank_sel), 16'd1);
    bus_nat.rd_en = 1; bus_nat.rd_addr_a = 5'd5; bus_nat.rd_addr_b = 5'd31;
    step("nat_rd");
    bus_nat.rd_en = 0;
    check("nat.addr5",  16'(bus_nat.rd_data_a), 16'h45);
    check("nat.addr31", 16'(bus_nat.rd_data_b), 16'h5F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
